deserializador: RTL
===================

# deserializador

Serial-to-parallel front end for the `fila` queue. It samples one bit per `clk_10KHz` cycle when `write_in` is high and assembles the bits MSB-first into a byte. It then presents the byte on `data_out` with a one-cycle `enqueue_out` pulse that drives `fila.enqueue_in`. Back-pressure comes from `fila.len_out`: a completed byte is held, and further bits are refused, until the queue has room.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; also the width of `data_out` and `len_in`.
- `DEPTH`, 8: queue capacity; the queue is full when `len_in >= DEPTH`.

Ports:
- `clk_10KHz`  in  1  single system clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high; has priority over every other input.
- `data_in`  in  1  serial bit, sampled when `write_in`=1.
- `write_in`  in  1  bit-valid strobe, one bit per cycle it is high.
- `len_in`  in  WIDTH  occupancy, connected to `fila.len_out`.
- `data_out`  out  WIDTH  assembled byte, connected to `fila.data_in`.
- `enqueue_out`  out  1  one-cycle push pulse, connected to `fila.enqueue_in`.
- `status_out`  out  1  1 = busy: bits are not accepted.

## Operation
- Two-state FSM:
  - `S_COLLECT`: `status_out`=0. On `write_in`=1: `sr <= {sr[WIDTH-2:0], data_in}` and `cnt++`. On the WIDTH-th accepted bit, latch the full byte into `data_out`, clear `cnt` and go to `S_READY`.
  - `S_READY`: `status_out`=1.
    - If `len_in < DEPTH`: drive `enqueue_out`=1 for the next cycle and return to `S_COLLECT`.
    - Otherwise stay in `S_READY` indefinitely.
- Bit order: the first accepted bit becomes `data_out[WIDTH-1]`.
- `write_in` pulses while `status_out`=1 are ignored. The bit is dropped and `cnt` is unchanged.
- `data_out` holds its value until the next byte completes. It never changes during or after an `enqueue_out` pulse until a new byte is assembled.
- Idle cycles (`write_in`=0) between bits do not disturb the partial byte.
- `cnt` width is `$clog2(WIDTH)`. It wraps to 0 exactly at byte completion.
- `len_in` values above `DEPTH` are treated as full.
- Reset mid-byte or in `S_READY` discards the partial or pending byte; no enqueue is issued for it.

## Timing
- Reset values (state after any edge with `reset`=1): state `S_COLLECT`, `cnt`=0, `sr`=0, `data_out`=0, `enqueue_out`=0, `status_out`=0.
- All outputs are registered.
- The WIDTH-th bit is sampled at edge k:
  - From k, `data_out` is valid and `status_out`=1.
  - If not full, `enqueue_out`=1 from edge k+1 to k+2, and `status_out` returns to 0 at k+1.
  - A bit presented in the cycle k to k+1 is dropped. A bit presented in the cycle k+1 to k+2 is accepted.
- Minimum spacing between `enqueue_out` pulses is WIDTH+1 cycles. `fila` has therefore updated `len_out` before the next full/not-full decision, so no double push is possible.
- Full case: if `len_in >= DEPTH` at every edge from k onward, `status_out` stays 1. The pulse occurs at the first edge where `len_in < DEPTH`.

## Structure
- Package `deserializador_pkg`:
  - `typedef enum logic {S_COLLECT, S_READY} state_t`.
  - Default `WIDTH` and `DEPTH` localparams, shared with `fila` and the top level.
- Single module: one FSM, one shift register, one bit counter. No sub-module.
- Top level wires `data_out`, `enqueue_out` and `len_in` directly to `fila`.

## Test plan
- Reset: hold `reset` for 2 cycles with `write_in`=1 → all outputs 0, no bits accepted.
- Single byte: `len_in`=0, bits 1,0,1,1,0,0,0,1 on consecutive cycles → `data_out`=8'hB1 after the 8th edge. `status_out` is high for exactly 1 cycle. `enqueue_out` pulses once, 1 cycle after the 8th bit.
- Back-pressure:
  - `len_in`=8, send 0x55 plus 3 extra bits → `status_out` stays 1, no `enqueue_out`, `data_out`=0x55 held, extra bits dropped.
  - Then drop `len_in` to 7 → one `enqueue_out` at the next edge.
- Reset mid-byte: 4 bits, then `reset` for 1 cycle, then bits of 0xA5 → `data_out`=0xA5, exactly one enqueue.
- Gapped bits: 0x3C with 1–3 idle cycles between bits → `data_out`=0x3C, one enqueue.
- Integration with a real `fila`, 9 bytes 0x11…0x99 back-to-back:
  - 8 enqueues; `len_out` reaches 8; the 9th byte (0x99) is held with `status_out`=1.
  - After one `fila` dequeue → 0x99 is enqueued and `len_out` returns to 8.

Source files
------------

// File: rtl/deserializador_pkg.sv
// Shared types and default sizes for the serial front end and the fila queue.
package deserializador_pkg;

    localparam int DEFAULT_WIDTH = 8;   // bits per word
    localparam int DEFAULT_DEPTH = 8;   // fila capacity in words

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_READY   = 1'b1
    } state_t;

endpackage

// File: rtl/deserializador.sv
// Serial-to-parallel front end: collects WIDTH bits MSB-first and pushes the
// completed word into fila with a one-cycle enqueue pulse, holding it while
// fila reports full.
module deserializador
    import deserializador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic [WIDTH-1:0] len_in,
    output logic [WIDTH-1:0] data_out,
    output logic             enqueue_out,
    output logic             status_out
);

    localparam int                 CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   DEPTH_LEN = WIDTH'(DEPTH);

    state_t           state;
    state_t           next_state;
    // Only the WIDTH-1 most recent bits need storing: the WIDTH-th bit goes
    // straight from data_in into data_out together with these.
    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             last_bit;
    logic             has_room;

    // Bit acceptance and queue-room decode
    always_comb begin
        shifted  = {sr, data_in};
        accept   = (state == S_COLLECT) && write_in;
        last_bit = accept && (cnt == LAST_BIT);
        // Occupancy above DEPTH is treated the same as exactly full.
        has_room = (len_in < DEPTH_LEN);
    end

    // State register
    always_ff @(posedge clk_10KHz) begin
        if (reset) state <= S_COLLECT;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_COLLECT: if (last_bit) next_state = S_READY;
            S_READY:   if (has_room) next_state = S_COLLECT;
            default:   next_state = S_COLLECT;
        endcase
    end

    // Busy flag decoded straight from the state register, so it is glitch-free
    always_comb begin
        status_out = (state == S_READY);
    end

    // Shift register, bit counter, output word and enqueue pulse
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            sr          <= '0;
            cnt         <= '0;
            data_out    <= '0;
            enqueue_out <= 1'b0;
        end else begin
            // Pulse lands in the cycle after the push decision, together with
            // the return to S_COLLECT.
            enqueue_out <= (state == S_READY) && has_room;
            if (accept) begin
                sr  <= shifted[WIDTH-2:0];
                cnt <= last_bit ? '0 : cnt + 1'b1;
            end
            // data_out only moves on word completion, so it is stable across
            // the whole hold and pulse window.
            if (last_bit) data_out <= shifted;
        end
    end

endmodule
